dma_write_checker: RTL and testbench
====================================

# dma_write_checker

Self-checking sink for the DMA write benchmark path: accepts the write command stream and write data stream that the benchmark write engine normally hands to the DMA core, and verifies them. It checks data-pattern continuity, TLAST placement against each command's length, and command/data pairing. It exposes counters and error status through the benchmark control/status register bank. Used in loopback builds in place of the DMA core, and as a bench reference sink.

## Interface
- No parameters; command FIFO depth fixed at 16 entries.
- clk  in  1  single clock.
- rstn  in  1  synchronous, active-low reset.
- s_axis_dma_write_cmd  axis_mem_cmd.slave  address 64 / length 32  write commands; ready driven here.
- s_axis_dma_write_data  axi_stream.slave  data 512 / keep 64 / last 1  write data; ready driven here.
- control_reg  in  16x32  [5]=expected ops, [7][0]=start, [9]=ready throttle pattern.
- status_reg  out  16x32  [0] ops done, [1] beats accepted, [2] pattern errors, [3] framing errors, [4] first error beat index, [5] cycles start→last op, [6][0] done, [6][1] error flag.

## Operation
- control_reg sampled into registers every cycle. Start pulse = start_r & ~start_rr, i.e. start level registered twice and rising edge taken.
- Start pulse clears every counter, the error flag, exp_base, the throttle pointer, and the command FIFO. The data FSM returns to IDLE.
- Command side: cmd.ready = FIFO not full. Each handshake pushes length[31:0]; the address is discarded.
- Beats per command = length>>6. A length that is 0 or not a multiple of 64 still pushes, but counts one framing error and is treated as 1 beat.
- Data FSM has three states:
  - IDLE: pop the FIFO head when non-empty, load beat_rem = beats, go to DATA.
  - DATA: accept beats. On the beat with beat_rem==1, go to IDLE if the FIFO is empty, otherwise pop and reload back-to-back with no bubble.
  - Data ready is 0 in IDLE.
- data.ready = (state==DATA) & throttle[ptr]. ptr is 5 bits, advances every cycle in DATA, wraps 31→0. Throttle pattern 0 is treated as all-ones.
- Per accepted beat:
  - Expected lane k (bits 32k+31:32k) = exp_base + k, for k=0..15, 32-bit wrap.
  - exp_base += 16 per beat, never reset per op.
  - Any lane mismatch, or keep ≠ all-ones, adds 1 to pattern errors (per beat, not per lane).
- Framing errors:
  - last=1 when beat_rem≠1: +1.
  - last=0 when beat_rem==1: +1.
  - The FSM still closes the op on beat_rem==1.
- Ops done increments on each completed op. done sets when ops done == control_reg[5] (non-zero); the cycle counter freezes there.
- The first error of either kind latches its beat index (beats accepted before that beat) and sets the error flag. Both clear only on start or reset.
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset: both readies 0, all status 0, FSM IDLE, FIFO empty. This is also the state before the first start.
- Command handshake to earliest data ready: 2 cycles (1-cycle FIFO write, then 1-cycle IDLE pop).
- status_reg registered: updates 1 cycle after the causing handshake.
- Cycle counter starts the cycle after the start pulse and stops counting in the cycle done sets.
- Start pulse with simultaneous handshakes: the start clear wins and those handshakes are not counted. A source must not drive valid in that cycle.
- Data valid with FIFO empty: ready stays 0 and the source stalls; this is not an error.
- Reset mid-operation returns everything to reset values within one cycle.

## Configuration
- DMA_WR_CHK_STOP_ON_ERR_EN defined: on the first error, both readies drop to 0 and stay 0 until the next start pulse or reset. Counters freeze at their values.
- Not defined: checking continues through errors and counters keep accumulating.

## Test plan
- Throttle 0, 4 commands of length 4096, matching pattern from exp_base 0 -> ops done=4, beats=256, errors 0, done=1, cycles ≈ 258.
- Throttle 0x5555_5555, same traffic -> identical counts; data ready asserts only on alternate cycles in DATA.
- Lane 7 of beat 10 corrupted -> pattern errors=1, first error index=10, error flag=1.
  - With the macro: both readies drop 1 cycle after beat 10.
- Length 4096 command, last asserted on beat 32 -> framing errors=2 (early last on beat 32, missing last on beat 64).
- Length 100 command -> framing +1, treated as 1 beat. 17 commands queued with data held off -> cmd.ready=0 after 16.
- Second start pulse mid-run -> all status 0, FIFO empty, exp_base 0; a new run passes cleanly.

Source files
------------

// File: rtl/dma_write_checker.sv
// dma_write_checker: sink that verifies DMA write cmd/data streams.
// Ports: clk, rstn (sync, active-low); s_axis_dma_write_cmd_* (valid/
// ready/address/length); s_axis_dma_write_data_* (valid/ready/data/keep/
// last); control_reg[16] in; status_reg[16] out.
// Option: DMA_WR_CHK_STOP_ON_ERR_EN halts both streams on first error.
module dma_write_checker (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_dma_write_cmd_valid,
  output logic                s_axis_dma_write_cmd_ready,
  input  logic [63:0]         s_axis_dma_write_cmd_address,
  input  logic [31:0]         s_axis_dma_write_cmd_length,
  input  logic                s_axis_dma_write_data_valid,
  output logic                s_axis_dma_write_data_ready,
  input  logic [511:0]        s_axis_dma_write_data_data,
  input  logic [63:0]         s_axis_dma_write_data_keep,
  input  logic                s_axis_dma_write_data_last,
  input  logic [15:0][31:0]   control_reg,
  output logic [15:0][31:0]   status_reg
);

  typedef enum logic [0:0] {S_IDLE, S_DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] exp_ops_r, thr_r, thr_eff;
  logic        start_r, start_rr, start_p, armed;
  logic [25:0] fifo_mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fifo_cnt, thr_ptr;
  logic        fifo_full, fifo_empty, pop;
  logic [25:0] beat_rem, beats_in;
  logic [31:0] exp_base;
  logic [31:0] ops_cnt, beat_cnt, pat_cnt, frm_cnt, first_idx, cyc_cnt;
  logic        done_q, err_q, halt;
  logic        cmd_hs, data_hs, len_bad, pat_bad, frm_beat;
  logic        last_beat, err_now, done_hit;
  logic [1:0]  frm_inc;
  logic        unused;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [1:0]  b);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign unused = ^{s_axis_dma_write_cmd_address,
                    control_reg[15:10], control_reg[8],
                    control_reg[7][31:1], control_reg[6],
                    control_reg[4:0]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      exp_ops_r <= '0;
      thr_r     <= '0;
      start_r   <= 1'b0;
      start_rr  <= 1'b0;
    end else begin
      exp_ops_r <= control_reg[5];
      thr_r     <= control_reg[9];
      start_r   <= control_reg[7][0];
      start_rr  <= start_r;
    end
  end

  assign start_p = start_r & ~start_rr;
  assign thr_eff = (thr_r == '0) ? 32'hFFFF_FFFF : thr_r;

`ifdef DMA_WR_CHK_STOP_ON_ERR_EN
  logic halt_q;
  always_ff @(posedge clk) begin
    if (!rstn)        halt_q <= 1'b0;
    else if (start_p) halt_q <= 1'b0;
    else if (err_now) halt_q <= 1'b1;
  end
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign fifo_full  = (fifo_cnt == 5'd16);
  assign fifo_empty = (fifo_cnt == 5'd0);

  // Readies stay low until the first start arms the checker.
  assign s_axis_dma_write_cmd_ready  = armed & ~fifo_full & ~halt;
  assign s_axis_dma_write_data_ready = (state_q == S_DATA) &
                                       thr_eff[thr_ptr] & ~halt;

  assign cmd_hs  = s_axis_dma_write_cmd_valid &
                   s_axis_dma_write_cmd_ready;
  assign data_hs = s_axis_dma_write_data_valid &
                   s_axis_dma_write_data_ready;

  // Malformed lengths still occupy one beat so the stream stays paired.
  assign len_bad  = (s_axis_dma_write_cmd_length == '0) |
                    (s_axis_dma_write_cmd_length[5:0] != 6'd0);
  assign beats_in = len_bad ? 26'd1 : s_axis_dma_write_cmd_length[31:6];

  always_ff @(posedge clk) begin
    if (cmd_hs) fifo_mem[wr_ptr] <= beats_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn || start_p) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (cmd_hs) wr_ptr <= wr_ptr + 4'd1;
      if (pop)    rd_ptr <= rd_ptr + 4'd1;
      fifo_cnt <= fifo_cnt + {4'd0, cmd_hs} - {4'd0, pop};
    end
  end

  assign last_beat = data_hs & (beat_rem == 26'd1);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !halt) begin
          pop     = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_beat) begin
          if (fifo_empty) state_d = S_IDLE;
          else            pop     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || start_p) begin
      state_q  <= S_IDLE;
      beat_rem <= '0;
      thr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (pop)          beat_rem <= fifo_mem[rd_ptr];
      else if (data_hs) beat_rem <= beat_rem - 26'd1;
      if (state_q == S_DATA) thr_ptr <= thr_ptr + 5'd1;
    end
  end

  always_comb begin
    pat_bad = (s_axis_dma_write_data_keep != '1);
    for (int k = 0; k < 16; k++) begin
      if (s_axis_dma_write_data_data[32*k +: 32] != exp_base + 32'(k))
        pat_bad = 1'b1;
    end
  end

  assign frm_beat = data_hs &
                    (s_axis_dma_write_data_last != (beat_rem == 26'd1));
  assign frm_inc  = {1'b0, frm_beat} + {1'b0, cmd_hs & len_bad};
  assign err_now  = (data_hs & pat_bad) | (frm_inc != 2'd0);
  assign done_hit = (exp_ops_r != '0) & (ops_cnt == exp_ops_r);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      armed     <= 1'b0;
      exp_base  <= '0;
      ops_cnt   <= '0;
      beat_cnt  <= '0;
      pat_cnt   <= '0;
      frm_cnt   <= '0;
      first_idx <= '0;
      cyc_cnt   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (start_p) begin
      armed     <= 1'b1;
      exp_base  <= '0;
      ops_cnt   <= '0;
      beat_cnt  <= '0;
      pat_cnt   <= '0;
      frm_cnt   <= '0;
      first_idx <= '0;
      cyc_cnt   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (data_hs) begin
        beat_cnt <= sat_add(beat_cnt, 2'd1);
        exp_base <= exp_base + 32'd16;
        if (pat_bad) pat_cnt <= sat_add(pat_cnt, 2'd1);
      end
      if (last_beat) ops_cnt <= sat_add(ops_cnt, 2'd1);
      frm_cnt <= sat_add(frm_cnt, frm_inc);
      if (err_now && !err_q) begin
        err_q     <= 1'b1;
        first_idx <= beat_cnt;
      end
      if (done_hit) done_q <= 1'b1;
      if (armed && !done_q && !done_hit && !halt)
        cyc_cnt <= sat_add(cyc_cnt, 2'd1);
    end
  end

  always_comb begin
    status_reg    = '0;
    status_reg[0] = ops_cnt;
    status_reg[1] = beat_cnt;
    status_reg[2] = pat_cnt;
    status_reg[3] = frm_cnt;
    status_reg[4] = first_idx;
    status_reg[5] = cyc_cnt;
    status_reg[6] = {30'd0, err_q, done_q};
  end

endmodule

// File: tb/tb_dma_write_checker.sv
// tb_dma_write_checker: directed stimulus with a status scoreboard.
// Expectations are queued by stimulus and compared by a monitor.
module tb_dma_write_checker;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cv, cready;
  logic [63:0]       caddr;
  logic [31:0]       clen;
  logic              dv, dready, dlast;
  logic [511:0]      ddata;
  logic [63:0]       dkeep;
  logic [15:0][31:0] control;
  logic [15:0][31:0] status;

  always #5 clk = ~clk;

  dma_write_checker dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .s_axis_dma_write_cmd_valid   (cv),
    .s_axis_dma_write_cmd_ready   (cready),
    .s_axis_dma_write_cmd_address (caddr),
    .s_axis_dma_write_cmd_length  (clen),
    .s_axis_dma_write_data_valid  (dv),
    .s_axis_dma_write_data_ready  (dready),
    .s_axis_dma_write_data_data   (ddata),
    .s_axis_dma_write_data_keep   (dkeep),
    .s_axis_dma_write_data_last   (dlast),
    .control_reg                  (control),
    .status_reg                   (status)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   consec = 0;
  bit   track  = 1'b0;
  logic prev_dr = 1'b0;

  // sel: 0..15 status word, 16 cmd ready, 17 data ready,
  // 18 count of back-to-back data-ready cycles while tracking.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (!track) consec = 0;
      else if (dready && prev_dr) consec++;
      prev_dr = dready;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.sel < 16)       act = status[e.sel];
        else if (e.sel == 16) act = {31'd0, cready};
        else if (e.sel == 17) act = {31'd0, dready};
        else                  act = 32'(consec);
        checks++;
        if (act < e.lo || act > e.hi) begin
          errors++;
          $display("FAIL %s: got %0d required %0d..%0d",
                   e.name, act, e.lo, e.hi);
        end
      end
    end
  end

  task automatic expect_eq(input string n, input int s,
                           input logic [31:0] v);
    sbq.push_back('{n, s, v, v});
  endtask

  task automatic expect_rng(input string n, input int s,
                            input logic [31:0] lo, input logic [31:0] hi);
    sbq.push_back('{n, s, lo, hi});
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s: timed out, required a handshake", n);
  endtask

  task automatic do_start(input logic [31:0] ops, input logic [31:0] thr);
    control[5] = ops;
    control[9] = thr;
    control[7] = 32'd0;
    repeat (3) @(posedge clk);
    #1 control[7] = 32'd1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] len, output bit ok);
    logic r;
    cv    = 1'b1;
    clen  = len;
    caddr = {$urandom, $urandom};
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = cready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1 cv = 1'b0;
    if (!ok) timeout("cmd_handshake");
  endtask

  task automatic send_beat(input int b, input int bad_lane,
                           input logic last, output bit ok);
    logic r;
    dv = 1'b1;
    for (int k = 0; k < 16; k++)
      ddata[32*k +: 32] = 32'(16*b + k) + ((k == bad_lane) ? 32'd1 : 32'd0);
    dkeep = '1;
    dlast = last;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = dready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) timeout("data_handshake");
  endtask

  task automatic send_beats(input int n, input int bpo, input int bad_beat,
                            input int bad_lane, input int fa, input int fb);
    bit   ok;
    logic last;
    for (int i = 0; i < n; i++) begin
      last = ((i % bpo) == bpo - 1) ^ (i == fa) ^ (i == fb);
      send_beat(i, (i == bad_beat) ? bad_lane : -1, last, ok);
      if (!ok) break;
    end
    dv = 1'b0;
  endtask

  task automatic send_cmds(input int n, input logic [31:0] len);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_cmd(len, ok);
      if (!ok) break;
    end
  endtask

  task automatic wait_done(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (status[6][0]) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
    if (!hit) timeout("done_wait");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rstn    = 1'b0;
    cv      = 1'b0;
    caddr   = '0;
    clen    = '0;
    dv      = 1'b0;
    ddata   = '0;
    dkeep   = '0;
    dlast   = 1'b0;
    control = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset / pre-start state
    expect_eq("rst_ops", 0, 0);
    expect_eq("rst_beats", 1, 0);
    expect_eq("rst_cycles", 5, 0);
    expect_eq("rst_flags", 6, 0);
    expect_eq("rst_cmd_ready", 16, 0);
    expect_eq("rst_data_ready", 17, 0);
    flush();

    // Clean run, no throttle
    do_start(4, 0);
    send_cmds(4, 4096);
    send_beats(256, 64, -1, -1, -1, -1);
    wait_done(50);
    expect_eq("t1_ops", 0, 4);
    expect_eq("t1_beats", 1, 256);
    expect_eq("t1_pat", 2, 0);
    expect_eq("t1_frm", 3, 0);
    expect_eq("t1_flags", 6, 1);
    expect_rng("t1_cycles", 5, 256, 280);
    flush();

    // Alternate-cycle throttle
    do_start(4, 32'h5555_5555);
    track = 1'b1;
    send_cmds(4, 4096);
    send_beats(256, 64, -1, -1, -1, -1);
    wait_done(50);
    expect_eq("t2_ops", 0, 4);
    expect_eq("t2_beats", 1, 256);
    expect_eq("t2_pat", 2, 0);
    expect_eq("t2_flags", 6, 1);
    expect_eq("t2_no_consec_ready", 18, 0);
    expect_rng("t2_cycles", 5, 505, 560);
    flush();
    track = 1'b0;

    // Lane 7 of beat 10 corrupted
    do_start(4, 0);
    send_cmds(4, 4096);
`ifdef DMA_WR_CHK_STOP_ON_ERR_EN
    send_beats(11, 64, 10, 7, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    expect_eq("t3_beats", 1, 11);
    expect_eq("t3_pat", 2, 1);
    expect_eq("t3_first", 4, 10);
    expect_eq("t3_flags", 6, 2);
    expect_eq("t3_cmd_ready", 16, 0);
    expect_eq("t3_data_ready", 17, 0);
`else
    send_beats(256, 64, 10, 7, -1, -1);
    wait_done(50);
    expect_eq("t3_ops", 0, 4);
    expect_eq("t3_beats", 1, 256);
    expect_eq("t3_pat", 2, 1);
    expect_eq("t3_frm", 3, 0);
    expect_eq("t3_first", 4, 10);
    expect_eq("t3_flags", 6, 3);
`endif
    flush();

    // Early last on beat 32, missing last on beat 64
    do_start(1, 0);
    send_cmds(1, 4096);
`ifdef DMA_WR_CHK_STOP_ON_ERR_EN
    send_beats(32, 64, -1, -1, 31, 63);
    repeat (2) @(posedge clk);
    #1;
    expect_eq("t4_frm", 3, 1);
    expect_eq("t4_beats", 1, 32);
    expect_eq("t4_flags", 6, 2);
`else
    send_beats(64, 64, -1, -1, 31, 63);
    wait_done(50);
    expect_eq("t4_frm", 3, 2);
    expect_eq("t4_ops", 0, 1);
    expect_eq("t4_beats", 1, 64);
    expect_eq("t4_pat", 2, 0);
    expect_eq("t4_flags", 6, 3);
`endif
    expect_eq("t4_first", 4, 31);
    flush();

    // Length 100: one framing error, treated as one beat
    do_start(1, 0);
    send_cmds(1, 100);
`ifdef DMA_WR_CHK_STOP_ON_ERR_EN
    repeat (3) @(posedge clk);
    #1;
    expect_eq("t5_ops", 0, 0);
    expect_eq("t5_flags", 6, 2);
`else
    send_beats(1, 1, -1, -1, -1, -1);
    wait_done(50);
    expect_eq("t5_ops", 0, 1);
    expect_eq("t5_beats", 1, 1);
    expect_eq("t5_flags", 6, 3);
`endif
    expect_eq("t5_frm", 3, 1);
    expect_eq("t5_first", 4, 0);
    flush();

    // FIFO fill with data held off: 16 queued + 1 at the FSM head
    do_start(0, 0);
    send_cmds(17, 64);
    repeat (2) @(posedge clk);
    #1;
    expect_eq("t5_fifo_full_ready", 16, 0);
    expect_eq("t5_fifo_ops", 0, 0);
    expect_eq("t5_fifo_frm", 3, 0);
    flush();

    // Restart mid-run
    do_start(4, 0);
    send_cmds(4, 4096);
    send_beats(50, 64, -1, -1, -1, -1);
    do_start(1, 0);
    expect_eq("t6_ops", 0, 0);
    expect_eq("t6_beats", 1, 0);
    expect_eq("t6_pat", 2, 0);
    expect_eq("t6_frm", 3, 0);
    expect_eq("t6_first", 4, 0);
    expect_eq("t6_flags", 6, 0);
    expect_eq("t6_cmd_ready", 16, 1);
    flush();
    dv = 1'b1;
    for (int k = 0; k < 16; k++) ddata[32*k +: 32] = 32'(k);
    dkeep = '1;
    dlast = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    expect_eq("t6_empty_data_ready", 17, 0);
    expect_eq("t6_empty_beats", 1, 0);
    flush();
    dv = 1'b0;
    send_cmds(1, 4096);
    send_beats(64, 64, -1, -1, -1, -1);
    wait_done(50);
    expect_eq("t6_new_ops", 0, 1);
    expect_eq("t6_new_beats", 1, 64);
    expect_eq("t6_new_pat", 2, 0);
    expect_eq("t6_new_frm", 3, 0);
    expect_eq("t6_new_flags", 6, 1);
    flush();
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
